cmp_flag_sequencer: RTL and testbench

//  Sequential front/back end for the 32-bit unsigned magnitude comparator.

---
 rtl/cmp_flag_sequencer.sv | 122 ++++++++++++
 tb/tb_cmp_flag_sequencer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmp_flag_sequencer.sv
// Sequencer around a 32-bit unsigned magnitude comparator: accepts an operand pair and a
// condition code, holds the pair on the comparator for SettleCycles clocks, samples GE/EQ,
// and returns the decoded condition plus the raw flags over a valid/ready handshake.
module cmp_flag_sequencer #(
  parameter int unsigned Width        = 32,
  parameter int unsigned SettleCycles = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [Width-1:0] in_a_i,
  input  logic [Width-1:0] in_b_i,
  input  logic [2:0]       in_cond_i,
  output logic [Width-1:0] cmp_a_o,
  output logic [Width-1:0] cmp_b_o,
  input  logic             cmp_ge_i,
  input  logic             cmp_eq_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             out_result_o,
  output logic             out_ge_o,
  output logic             out_eq_o,
  output logic             busy_o
);

  // The settle counter is 4 bits wide, so the hold time is capped at 15 clocks.
  if (SettleCycles == 0 || SettleCycles > 15) begin : gen_settle_range_check
    $error("cmp_flag_sequencer: SettleCycles must lie in 1..15");
  end

  localparam logic [3:0] CntLoad = 4'(SettleCycles - 1);

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StOut
  } state_e;

  state_e             state_q;
  logic [3:0]         cnt_q;
  logic [2:0]         cond_q;
  logic [Width-1:0]   cmp_a_q;
  logic [Width-1:0]   cmp_b_q;
  logic               out_valid_q;
  logic               out_result_q;
  logic               out_ge_q;
  logic               out_eq_q;
  logic               result_d;

  // Decode the latched condition against the live comparator flags; the flags are used
  // as-is, even if the GE/EQ combination is inconsistent.
  always_comb begin
    result_d = 1'b0;
    unique case (cond_q)
      3'd0: result_d = cmp_eq_i;               // EQ
      3'd1: result_d = ~cmp_eq_i;              // NE
      3'd2: result_d = cmp_ge_i;               // GE
      3'd3: result_d = ~cmp_ge_i;              // LT
      3'd4: result_d = cmp_ge_i & ~cmp_eq_i;   // GT
      3'd5: result_d = ~cmp_ge_i | cmp_eq_i;   // LE
      3'd6: result_d = 1'b1;                   // ALWAYS
      3'd7: result_d = 1'b0;                   // NEVER
    endcase
  end

  // Control FSM with registered operand and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= 4'd0;
      cond_q       <= 3'd0;
      cmp_a_q      <= '0;
      cmp_b_q      <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= 1'b0;
      out_ge_q     <= 1'b0;
      out_eq_q     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // Operands only move on accept, so the comparator stays quiet between requests.
          if (in_valid_i) begin
            cmp_a_q <= in_a_i;
            cmp_b_q <= in_b_i;
            cond_q  <= in_cond_i;
            cnt_q   <= CntLoad;
            state_q <= StSettle;
          end
        end
        StSettle: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            out_ge_q     <= cmp_ge_i;
            out_eq_q     <= cmp_eq_i;
            out_result_q <= result_d;
            out_valid_q  <= 1'b1;
            state_q      <= StOut;
          end
        end
        StOut: begin
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready_o   = (state_q == StIdle);
  assign busy_o       = (state_q != StIdle);
  assign cmp_a_o      = cmp_a_q;
  assign cmp_b_o      = cmp_b_q;
  assign out_valid_o  = out_valid_q;
  assign out_result_o = out_result_q;
  assign out_ge_o     = out_ge_q;
  assign out_eq_o     = out_eq_q;

endmodule

// File: tb/tb_cmp_flag_sequencer.sv
// Directed bench for cmp_flag_sequencer: a SettleCycles=2 instance and a SettleCycles=1
// instance, each driving an ideal combinational comparator model.
module tb_cmp_flag_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Instance with the default settle time.
  logic        in_valid, in_ready, busy, out_valid, out_ready, out_result, out_ge, out_eq;
  logic        cmp_ge, cmp_eq;
  logic [31:0] in_a, in_b, cmp_a, cmp_b;
  logic [2:0]  in_cond;

  assign cmp_ge = (cmp_a >= cmp_b);
  assign cmp_eq = (cmp_a == cmp_b);

  cmp_flag_sequencer #(.Width(32), .SettleCycles(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .in_a_i       (in_a),
    .in_b_i       (in_b),
    .in_cond_i    (in_cond),
    .cmp_a_o      (cmp_a),
    .cmp_b_o      (cmp_b),
    .cmp_ge_i     (cmp_ge),
    .cmp_eq_i     (cmp_eq),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_result_o (out_result),
    .out_ge_o     (out_ge),
    .out_eq_o     (out_eq),
    .busy_o       (busy)
  );

  // Single-cycle settle instance; its comparator flags can be overridden.
  logic        s1_in_valid, s1_in_ready, s1_busy, s1_out_valid, s1_out_ready;
  logic        s1_out_result, s1_out_ge, s1_out_eq, s1_cmp_ge, s1_cmp_eq;
  logic        s1_ovr, s1_ovr_ge, s1_ovr_eq;
  logic [31:0] s1_in_a, s1_in_b, s1_cmp_a, s1_cmp_b;
  logic [2:0]  s1_in_cond;

  assign s1_cmp_ge = s1_ovr ? s1_ovr_ge : (s1_cmp_a >= s1_cmp_b);
  assign s1_cmp_eq = s1_ovr ? s1_ovr_eq : (s1_cmp_a == s1_cmp_b);

  cmp_flag_sequencer #(.Width(32), .SettleCycles(1)) dut_s1 (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid_i   (s1_in_valid),
    .in_ready_o   (s1_in_ready),
    .in_a_i       (s1_in_a),
    .in_b_i       (s1_in_b),
    .in_cond_i    (s1_in_cond),
    .cmp_a_o      (s1_cmp_a),
    .cmp_b_o      (s1_cmp_b),
    .cmp_ge_i     (s1_cmp_ge),
    .cmp_eq_i     (s1_cmp_eq),
    .out_valid_o  (s1_out_valid),
    .out_ready_i  (s1_out_ready),
    .out_result_o (s1_out_result),
    .out_ge_o     (s1_out_ge),
    .out_eq_o     (s1_out_eq),
    .busy_o       (s1_busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Offer one request to the main instance; returns just after the accept edge.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [2:0] c);
    int w = 0;
    while (!in_ready && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    check_eq("send_ready", {31'd0, in_ready}, 32'd1);
    in_a = a; in_b = b; in_cond = c; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    // Junk outside the accept cycle must be ignored.
    in_a = 32'hFFFF_FFFF; in_b = 32'h0; in_cond = 3'd7;
  endtask

  // Wait for the result (called just after the accept edge), check it, then take it.
  task automatic collect(input string tag, input logic r, input logic ge, input logic eq,
                         input logic [31:0] a, input logic [31:0] b);
    int lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq({tag, "_lat"}, lat, 32'd2);
    check_eq({tag, "_res"}, {31'd0, out_result}, {31'd0, r});
    check_eq({tag, "_ge"}, {31'd0, out_ge}, {31'd0, ge});
    check_eq({tag, "_eq"}, {31'd0, out_eq}, {31'd0, eq});
    check_eq({tag, "_cmp_a"}, cmp_a, a);
    check_eq({tag, "_cmp_b"}, cmp_b, b);
    check_eq({tag, "_rdy_out"}, {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_eq({tag, "_drop"}, {31'd0, out_valid}, 32'd0);
    check_eq({tag, "_idle"}, {31'd0, in_ready}, 32'd1);
  endtask

  // Full transaction on the single-cycle instance, starting from idle.
  task automatic s1_run(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] c, input logic ovr, input logic oge,
                        input logic oeq, input logic r);
    int lat = 0;
    s1_ovr = ovr; s1_ovr_ge = oge; s1_ovr_eq = oeq;
    check_eq({tag, "_ready"}, {31'd0, s1_in_ready}, 32'd1);
    s1_in_a = a; s1_in_b = b; s1_in_cond = c; s1_in_valid = 1'b1;
    @(posedge clk); #1;
    s1_in_valid = 1'b0;
    while (!s1_out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq({tag, "_lat"}, lat, 32'd1);
    check_eq({tag, "_res"}, {31'd0, s1_out_result}, {31'd0, r});
    s1_out_ready = 1'b1;
    @(posedge clk); #1;
    s1_out_ready = 1'b0;
    check_eq({tag, "_drop"}, {31'd0, s1_out_valid}, 32'd0);
    check_eq({tag, "_busy"}, {31'd0, s1_busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] exp_cond [8];
    logic [31:0] prev_a, drv_a;
    int          last_acc, n_acc, w;
    logic        seen;

    exp_cond = '{32'd1, 32'd0, 32'd1, 32'd0, 32'd0, 32'd1, 32'd1, 32'd0};
    rst_n = 1'b0;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_cond = '0; out_ready = 1'b0;
    s1_in_valid = 1'b0; s1_in_a = '0; s1_in_b = '0; s1_in_cond = '0; s1_out_ready = 1'b0;
    s1_ovr = 1'b0; s1_ovr_ge = 1'b0; s1_ovr_eq = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: reset state, then 5 > 3 under GT.
    check_eq("rst_ready", {31'd0, in_ready}, 32'd1);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_cmp_a", cmp_a, 32'd0);
    check_eq("rst_result", {31'd0, out_result}, 32'd0);
    send(32'd5, 32'd3, 3'd4);
    check_eq("t1_busy", {31'd0, busy}, 32'd1);
    collect("t1", 1'b1, 1'b1, 1'b0, 32'd5, 32'd3);

    // 2: equal operands under every condition code.
    for (int c = 0; c < 8; c++) begin
      send(32'hDEAD_BEEF, 32'hDEAD_BEEF, 3'(c));
      collect($sformatf("cond%0d", c), exp_cond[c][0], 1'b1, 1'b1,
              32'hDEAD_BEEF, 32'hDEAD_BEEF);
    end

    // 3: backpressure while a new request waits on in_valid.
    send(32'd0, 32'hFFFF_FFFF, 3'd3);
    w = 0;
    while (!out_valid && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    check_eq("bp_lat", w, 32'd2);
    in_a = 32'd9; in_b = 32'd9; in_cond = 3'd0; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check_eq("bp_valid", {31'd0, out_valid}, 32'd1);
      check_eq("bp_result", {31'd0, out_result}, 32'd1);
      check_eq("bp_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
    end
    check_eq("bp_ge", {31'd0, out_ge}, 32'd0);
    check_eq("bp_cmp_a", cmp_a, 32'd0);
    check_eq("bp_cmp_b", cmp_b, 32'hFFFF_FFFF);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_eq("bp_drop", {31'd0, out_valid}, 32'd0);
    check_eq("bp_no_accept_yet", cmp_a, 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_eq("held_accept", cmp_a, 32'd9);
    collect("held", 1'b1, 1'b1, 1'b1, 32'd9, 32'd9);

    // 4: continuous in_valid and out_ready; accepts are SettleCycles+2 apart.
    out_ready = 1'b1; in_valid = 1'b1; in_cond = 3'd6;
    last_acc = 0; n_acc = 0;
    for (int i = 0; i < 17; i++) begin
      in_a = 32'h1000 + 32'(i);
      in_b = ~in_a;
      prev_a = cmp_a;
      drv_a = in_a;
      @(posedge clk); #1;
      if (cmp_a !== prev_a) begin
        check_eq("b2b_val", cmp_a, drv_a);
        if (n_acc > 0) check_eq("b2b_gap", i - last_acc, 32'd4);
        last_acc = i;
        n_acc++;
      end
    end
    in_valid = 1'b0;
    check_eq("b2b_count", n_acc, 32'd5);
    w = 0;
    while (!in_ready && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    out_ready = 1'b0;
    check_eq("b2b_last_res", {31'd0, out_result}, 32'd1);

    // 5: reset during SETTLE aborts the request.
    send(32'd7, 32'd9, 3'd2);
    @(posedge clk); #1;
    check_eq("abort_pre", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("abort_cmp_a", cmp_a, 32'd0);
    check_eq("abort_cmp_b", cmp_b, 32'd0);
    check_eq("abort_valid", {31'd0, out_valid}, 32'd0);
    check_eq("abort_result", {31'd0, out_result}, 32'd0);
    check_eq("abort_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("abort_ready", {31'd0, in_ready}, 32'd1);
    seen = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      seen = seen | out_valid;
    end
    check_eq("abort_no_stale", {31'd0, seen}, 32'd0);

    // 6: single-cycle settle instance, including flags taken as-is.
    s1_run("s1_le", 32'd1, 32'd2, 3'd5, 1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("s1_le_ge", {31'd0, s1_out_ge}, 32'd0);
    check_eq("s1_le_eq", {31'd0, s1_out_eq}, 32'd0);
    check_eq("s1_cmp_a", s1_cmp_a, 32'd1);
    s1_run("s1_ovr_eq", 32'd1, 32'd2, 3'd0, 1'b1, 1'b0, 1'b1, 1'b1);
    check_eq("s1_ovr_flag", {31'd0, s1_out_eq}, 32'd1);
    s1_run("s1_ovr_gt", 32'd1, 32'd2, 3'd4, 1'b1, 1'b1, 1'b1, 1'b0);
    s1_run("s1_ne", 32'd5, 32'd5, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
